// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment scan driver with per-digit enable and decimal point.
// Also provides leading-zero blanking, PWM brightness and selectable output polarity.
// Display data moves into shadow registers only at frame boundaries, so a frame never tears.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   x            - hex digits, 4 bits per digit; digit 0 (rightmost) is x[3:0]
//   dp_in        - decimal point per digit
//   digit_en     - per-digit enable
//   lz_suppress  - leading-zero blanking enable
//   brightness   - PWM duty code (all-ones = full on, 0 = dark); sampled live
//   load         - request capture of x/dp_in/digit_en/lz_suppress at the next frame boundary
//   load_ack     - one-cycle pulse after the shadow registers are updated
//   frame_start  - one-cycle pulse when the scan wraps to digit 0
//   seg          - segments in gfedcba order
//   dp           - decimal point
//   an           - digit anodes, at most one active
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PRESCALE_W = 17,
  parameter int unsigned BRIGHT_W   = 3,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] x,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [PRESCALE_W-1:0]   prescaler;
  logic [IDX_W-1:0]        idx;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] x_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   en_sh;
  logic                    lz_sh;

  logic                    tick_c;
  logic                    boundary_c;
  logic                    capture_c;
  logic [NUM_DIGITS-1:0]   nz_from_c;
  logic                    nz_run_c;
  logic                    suppressed_c;
  logic [BRIGHT_W-1:0]     pw_c;
  logic                    gate_c;
  logic                    lit_c;
  logic [3:0]              nib_c;
  logic [NUM_DIGITS-1:0]   an_c;
  logic [6:0]              seg_c;
  logic                    dp_c;

  // Hex glyphs, active-low gfedcba
  function automatic logic [6:0] glyph_low(input logic [3:0] v);
    case (v)
      4'h0: glyph_low = 7'h40;
      4'h1: glyph_low = 7'h79;
      4'h2: glyph_low = 7'h24;
      4'h3: glyph_low = 7'h30;
      4'h4: glyph_low = 7'h19;
      4'h5: glyph_low = 7'h12;
      4'h6: glyph_low = 7'h02;
      4'h7: glyph_low = 7'h78;
      4'h8: glyph_low = 7'h00;
      4'h9: glyph_low = 7'h10;
      4'hA: glyph_low = 7'h08;
      4'hB: glyph_low = 7'h03;
      4'hC: glyph_low = 7'h46;
      4'hD: glyph_low = 7'h21;
      4'hE: glyph_low = 7'h06;
      default: glyph_low = 7'h0E;
    endcase
  endfunction

  // Scan timing and capture decision
  always_comb begin
    tick_c     = &prescaler;
    boundary_c = tick_c && (idx == LAST_IDX);
    capture_c  = boundary_c && (pending || load);
  end

  // nz_from_c[i] = some shadow nibble at position i or above is non-zero
  always_comb begin
    nz_from_c = '0;
    nz_run_c  = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nz_run_c     = nz_run_c | (|x_sh[4*i +: 4]);
      nz_from_c[i] = nz_run_c;
    end
  end

  // Digit visibility and active-high glyph for the current scan slot
  always_comb begin
    nib_c        = x_sh[4*idx +: 4];
    suppressed_c = lz_sh && (idx != '0) && !nz_from_c[idx];
    pw_c         = prescaler[PRESCALE_W-1 -: BRIGHT_W];
    gate_c       = (&brightness) || (pw_c < brightness);
    lit_c        = en_sh[idx] && !suppressed_c && gate_c;
    an_c         = '0;
    seg_c        = '0;
    dp_c         = 1'b0;
    if (lit_c) begin
      an_c  = NUM_DIGITS'(1) << idx;
      seg_c = ~glyph_low(nib_c);
      dp_c  = dp_sh[idx];
    end
  end

  // Prescaler, scan index and load handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      x_sh        <= '0;
      dp_sh       <= '0;
      en_sh       <= '0;
      lz_sh       <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= prescaler + PRESCALE_W'(1);
      if (tick_c) idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      if (capture_c) begin
        pending <= 1'b0;
        x_sh    <= x;
        dp_sh   <= dp_in;
        en_sh   <= digit_en;
        lz_sh   <= lz_suppress;
      end else if (load) begin
        pending <= 1'b1;
      end
      load_ack    <= capture_c;
      frame_start <= boundary_c;
    end
  end

  // Output stage with polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= {NUM_DIGITS{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      an  <= an_c ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg <= seg_c ^ {7{ACTIVE_LOW}};
      dp  <= dp_c ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit active-low instance and an
// 8-digit active-high instance, both with a 16-clock scan slot.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x;
  logic [3:0]  dp_in, digit_en;
  logic        lz_suppress, load;
  logic [2:0]  brightness;
  logic        load_ack, frame_start, dp;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic [31:0] x8;
  logic [7:0]  dp_in8, digit_en8;
  logic        lz8, load8;
  logic [2:0]  bright8;
  logic        load_ack8, frame_start8, dp8;
  logic [6:0]  seg8;
  logic [7:0]  an8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE_W(4), .BRIGHT_W(3), .ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rst(rst), .x(x), .dp_in(dp_in), .digit_en(digit_en),
    .lz_suppress(lz_suppress), .brightness(brightness), .load(load),
    .load_ack(load_ack), .frame_start(frame_start), .seg(seg), .dp(dp), .an(an)
  );

  seg7_scan_driver #(.NUM_DIGITS(8), .PRESCALE_W(4), .BRIGHT_W(3), .ACTIVE_LOW(1'b0)) u_dut8 (
    .clk(clk), .rst(rst), .x(x8), .dp_in(dp_in8), .digit_en(digit_en8),
    .lz_suppress(lz8), .brightness(bright8), .load(load8),
    .load_ack(load_ack8), .frame_start(frame_start8), .seg(seg8), .dp(dp8), .an(an8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Active-low gfedcba glyph table
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Pulse load on the 4-digit instance
  task automatic pulse_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Advance until load_ack is seen; leaves time just after the ack edge (scan at digit 0)
  task automatic sync_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (load_ack) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("ack_seen", 32'(seen), 32'd1);
    check("ack_with_frame_start", 32'(frame_start), 32'd1);
  endtask

  // Check one full 64-clock frame of the 4-digit instance against expected shadow contents
  task automatic check_frame(input logic [15:0] ex, input logic [3:0] edp, input logic [3:0] een,
                             input logic elz, input logic [2:0] eb, output int lit_cycles);
    logic       lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] one;
    lit_cycles = 0;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 16; k++) begin
        step();
        lit = een[d] && !(elz && d > 0 && (ex >> (4 * d)) == 16'h0) && (eb == 3'd7 || (k >> 1) < eb);
        one = 4'b0001 << d;
        e_an  = lit ? ~one : 4'hF;
        e_seg = lit ? glyph(ex[4*d +: 4]) : 7'h7F;
        e_dp  = lit ? ~edp[d] : 1'b1;
        if (an != 4'hF) lit_cycles++;
        check($sformatf("an d%0d k%0d", d, k), 32'(an), 32'(e_an));
        check($sformatf("seg d%0d k%0d", d, k), 32'(seg), 32'(e_seg));
        check($sformatf("dp d%0d k%0d", d, k), 32'(dp), 32'(e_dp));
        check($sformatf("frame_start d%0d k%0d", d, k), 32'(frame_start), (d == 3 && k == 15) ? 32'd1 : 32'd0);
        check($sformatf("no_ack d%0d k%0d", d, k), 32'(load_ack), 32'd0);
      end
    end
  endtask

  initial begin
    int lit;
    int acks;
    bit seen;
    logic [7:0] one8;
    logic [6:0] e_seg8;

    rst = 1'b1; x = '0; dp_in = '0; digit_en = '0; lz_suppress = 1'b0; load = 1'b0; brightness = 3'd7;
    x8 = '0; dp_in8 = '0; digit_en8 = '0; lz8 = 1'b0; load8 = 1'b0; bright8 = 3'd7;
    repeat (3) step();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_ack", 32'(load_ack), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_an8", 32'(an8), 32'h00);
    check("rst_seg8", 32'(seg8), 32'h00);
    rst = 1'b0;

    // No load yet: display stays blank and no ack appears
    acks = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (an != 4'hF || seg != 7'h7F) check("blank_before_load", {25'd0, seg}, 32'h7F);
      if (load_ack) acks++;
    end
    check("blank_an_end", 32'(an), 32'hF);
    check("no_ack_before_load", 32'(acks), 32'd0);

    // Basic capture and scan order
    x = 16'h12AF; digit_en = 4'hF; dp_in = 4'b0100; brightness = 3'd7;
    pulse_load();
    sync_ack();
    check_frame(16'h12AF, 4'b0100, 4'hF, 1'b0, 3'd7, lit);
    check("full_lit_cycles", 32'(lit), 32'd64);

    // Inputs sampled at the boundary, repeated load gives one ack
    repeat (20) step();
    x = 16'h0005;
    pulse_load();
    repeat (5) step();
    x = 16'h0007;
    pulse_load();
    sync_ack();
    check_frame(16'h0007, 4'b0100, 4'hF, 1'b0, 3'd7, lit);

    // Leading-zero suppression
    x = 16'h0050; lz_suppress = 1'b1; dp_in = 4'h0;
    pulse_load();
    sync_ack();
    check_frame(16'h0050, 4'h0, 4'hF, 1'b1, 3'd7, lit);
    check("lz_lit_cycles", 32'(lit), 32'd32);
    x = 16'h0000;
    pulse_load();
    sync_ack();
    check_frame(16'h0000, 4'h0, 4'hF, 1'b1, 3'd7, lit);
    check("lz_zero_lit_cycles", 32'(lit), 32'd16);

    // PWM brightness
    x = 16'h12AF; lz_suppress = 1'b0; dp_in = 4'b0100;
    pulse_load();
    sync_ack();
    brightness = 3'd2;
    check_frame(16'h12AF, 4'b0100, 4'hF, 1'b0, 3'd2, lit);
    check("pwm2_lit_cycles", 32'(lit), 32'd16);
    brightness = 3'd0;
    check_frame(16'h12AF, 4'b0100, 4'hF, 1'b0, 3'd0, lit);
    check("pwm0_lit_cycles", 32'(lit), 32'd0);

    // Reset mid-frame clears shadows and discards a pending load
    brightness = 3'd7;
    pulse_load();
    repeat (10) step();
    rst = 1'b1;
    step();
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_dp", 32'(dp), 32'd1);
    check("mid_rst_ack", 32'(load_ack), 32'd0);
    check("mid_rst_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    acks = 0;
    lit = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (load_ack) acks++;
      if (an != 4'hF) lit++;
    end
    check("post_rst_no_ack", 32'(acks), 32'd0);
    check("post_rst_blank", 32'(lit), 32'd0);

    // Active-high 8-digit instance
    x8 = 32'h89ABCDEF; digit_en8 = 8'hFF; dp_in8 = 8'h00; bright8 = 3'd7;
    load8 = 1'b1;
    step();
    load8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (load_ack8) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("ack8_seen", 32'(seen), 32'd1);
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < 16; k++) begin
        step();
        one8 = 8'h01 << d;
        e_seg8 = ~glyph(x8[4*d +: 4]);
        check($sformatf("an8 d%0d k%0d", d, k), 32'(an8), 32'(one8));
        check($sformatf("seg8 d%0d k%0d", d, k), 32'(seg8), 32'(e_seg8));
        check($sformatf("dp8 d%0d k%0d", d, k), 32'(dp8), 32'd0);
        check($sformatf("onehot8 d%0d k%0d", d, k), 32'($countones(an8)), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multiplexed 7-segment driver for NUM_DIGITS hex digits.
- Adds per-digit enable, per-digit decimal points, leading-zero suppression, PWM brightness and configurable output polarity.
- Adds a tear-free load handshake: display data is captured into shadow registers only at frame boundaries.
- Sits between the ATM display-formatting logic and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 8, number of scanned digits (1..16)
PRESCALE_W, 17, prescaler width; scan advances once every 2^PRESCALE_W clocks (must be >= BRIGHT_W)
BRIGHT_W, 3, brightness control width
ACTIVE_LOW, 1, 1: seg/an/dp active-low; 0: active-high

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
x  in  4*NUM_DIGITS  hex value; digit i = x[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point per digit
digit_en  in  NUM_DIGITS  1 = digit may light
lz_suppress  in  1  enable leading-zero blanking
brightness  in  BRIGHT_W  PWM duty code
load  in  1  request capture of x/dp_in/digit_en/lz_suppress
load_ack  out  1  one-cycle pulse: shadow registers updated
frame_start  out  1  one-cycle pulse when scan wraps to digit 0
seg  out  7  segments, gfedcba order
dp  out  1  decimal point
an  out  NUM_DIGITS  digit anodes

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset state:
  - prescaler, scan index, pending flag = 0.
  - Shadow x/dp/en/lz = 0, so all digits blank until the first load.
  - Registered outputs go inactive: an all off, seg all off, dp off, load_ack = 0, frame_start = 0.
  - Reset mid-frame discards any pending load.
- Prescaler: free-running, increments every clk; tick = prescaler all-ones.
- Scan index: on tick, index <= (index == NUM_DIGITS-1) ? 0 : index+1.
- Frame boundary: the tick taken while index == NUM_DIGITS-1.
  - frame_start pulses the cycle after the boundary tick, coincident with index = 0.
- Load handshake:
  - load = 1 sets pending.
  - On a frame boundary with pending = 1, or with load = 1 in that same cycle, the shadows capture the live inputs in that cycle and pending clears.
  - load_ack pulses in the following cycle.
  - Repeated load while pending produces no extra ack; the inputs are sampled at the boundary, not at the load cycle.
  - Inputs are ignored between captures.
- Leading-zero suppression: digit i > 0 is suppressed when lz_sh = 1 and shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed.
- PWM gate:
  - pw = prescaler[PRESCALE_W-1 -: BRIGHT_W].
  - Gate on when brightness is all-ones, or pw < brightness.
  - Result: code 0 = dark, code k = k/2^BRIGHT_W duty, max code = full on.
  - brightness is sampled live, not shadowed.
- Digit lit = en_sh[index] & ~suppressed(index) & gate.
- Glyph table, active-low gfedcba, hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
- Outputs: single register stage, 1-cycle latency from index/prescaler state.
  - Lit digit: an = only bit[index] active; seg = glyph(x_sh[index]); dp = dp_sh[index].
  - Unlit digit: an, seg and dp all inactive.
  - ACTIVE_LOW = 0 inverts all three outputs.
- Never more than one anode active.

Test Plan:
1. PRESCALE_W=4, NUM_DIGITS=4, reset, no load -> an=4'b1111, seg=7'h7F for 200 cycles; load_ack never asserts.
2. x=16'h12AF, digit_en=4'hF, dp_in=4'b0100, brightness=7, pulse load -> load_ack one cycle after the first boundary.
   - The following frame shows an 1110/1101/1011/0111 for 16 clocks each.
   - seg = 0E/08/24/79; dp low only while an=1011.
   - frame_start every 64 clocks.
3. Load x=16'h0005 mid-frame, then change x to 16'h0007 before the boundary -> displayed digit 0 glyph = 78 (value 7 sampled at the boundary); a second load while pending gives a single ack.
4. x=16'h0050, lz_suppress=1 -> digits 3 and 2 blank; digit 1 = 12; digit 0 = 40. With x=16'h0000, digit 0 still shows 40.
5. brightness=2 (BRIGHT_W=3, PRESCALE_W=4) -> each anode is active for 4 of its 16 clocks (pw 0..1); brightness=0 -> an all inactive; asserting rst mid-frame -> next cycle all outputs inactive and shadows cleared.
6. ACTIVE_LOW=0, NUM_DIGITS=8, x=32'h89ABCDEF -> outputs are the bitwise inverse of the active-low case; exactly one an bit high at any time.
